// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the register file's single write port between two writeback sources
// and keeps a per-register busy scoreboard that decode uses for RAW hazard
// detection.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   s0_valid/addr/data/ready    source 0 (ALU) writeback request
//   s1_valid/addr/data/ready    source 1 (load / multi-cycle) writeback request
//   iss_valid, iss_addr         decode issued an instruction writing iss_addr
//   rd_addr1, rd_addr2          decode read addresses
//   busy1, busy2                read address has a write outstanding (comb)
//   reg_write, addr3, wdata     registered register-file write port
//
// Handshake: a source presents valid with stable addr/data until it sees
// ready. ready is combinational and never asserted without valid. A transfer
// happens on the rising edge where valid & ready are both high. The winning
// write reaches the register file (reg_write/addr3/wdata) one edge later.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_valid,
  input  logic [AW-1:0] s0_addr,
  input  logic [DW-1:0] s0_data,
  output logic          s0_ready,
  input  logic          s1_valid,
  input  logic [AW-1:0] s1_addr,
  input  logic [DW-1:0] s1_data,
  output logic          s1_ready,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_addr,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          busy1,
  output logic          busy2,
  output logic          reg_write,
  output logic [AW-1:0] addr3,
  output logic [DW-1:0] wdata
);

  // last_grant: 0 = src0 won the most recent transfer, 1 = src1 did.
  logic            last_grant_q, last_grant_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            reg_write_q, reg_write_d;
  logic [AW-1:0]   addr3_q, addr3_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            grant0, grant1;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // Arbitration: on a conflict the round-robin pointer favours whichever
  // source did not win last; fixed-priority mode always favours src0.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (s0_valid && s1_valid) begin
      if ((FIXED_PRIO != 0) || last_grant_q) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else if (s0_valid) begin
      grant0 = 1'b1;
    end else if (s1_valid) begin
      grant1 = 1'b1;
    end
  end

  assign s0_ready = grant0;
  assign s1_ready = grant1;
  assign xfer     = grant0 | grant1;
  assign sel_addr = grant1 ? s1_addr : s0_addr;
  assign sel_data = grant1 ? s1_data : s0_data;

  // Output stage and pointer update.
  always_comb begin
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    addr3_d      = addr3_q;
    wdata_d      = wdata_q;
    if (xfer) begin
      last_grant_d = grant1;
      // r0 writes are accepted from the source but never reach the file.
      reg_write_d  = (sel_addr != '0);
      addr3_d      = sel_addr;
      wdata_d      = sel_data;
    end
  end

  // Scoreboard: the clear is applied before the set so that a new producer
  // issued on the commit edge of the previous one keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) begin
      busy_d[addr3_q] = 1'b0;
    end
    if (iss_valid && (iss_addr != '0)) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      busy_q       <= '0;
      reg_write_q  <= 1'b0;
      addr3_q      <= '0;
      wdata_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      reg_write_q  <= reg_write_d;
      addr3_q      <= addr3_d;
      wdata_q      <= wdata_d;
    end
  end

  assign busy1     = busy_q[rd_addr1];
  assign busy2     = busy_q[rd_addr2];
  assign reg_write = reg_write_q;
  assign addr3     = addr3_q;
  assign wdata     = wdata_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: src0 (ALU) and src1 (load/multi-cycle unit).
- Holds a per-register busy scoreboard, used by the decode stage for RAW hazard detection on the two read addresses.
- Sits between the execute/memory stages and the register file. Drives the register file's reg_write, addr3 and wdata inputs from registered outputs.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register address width; must equal log2(NREG).
- DW, 32, data width.
- FIXED_PRIO, 0, arbitration mode: 0 = round-robin, 1 = src0 always wins.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s0_valid  in  1  src0 has a write pending.
- s0_addr  in  AW  src0 destination register.
- s0_data  in  DW  src0 write data.
- s0_ready  out  1  src0 write accepted this cycle (combinational).
- s1_valid, s1_addr, s1_data, s1_ready  same as src0, for src1.
- iss_valid  in  1  decode issues an instruction that will write iss_addr.
- iss_addr  in  AW  destination register of the issued instruction.
- rd_addr1  in  AW  read address 1, the same value driven to the register file's addr1.
- rd_addr2  in  AW  read address 2, the same value driven to the register file's addr2.
- busy1  out  1  register rd_addr1 has a write outstanding (combinational).
- busy2  out  1  register rd_addr2 has a write outstanding (combinational).
- reg_write  out  1  write enable to the register file (registered).
- addr3  out  AW  write address to the register file (registered).
- wdata  out  DW  write data to the register file (registered).

Behaviour:
- Reset (async, rst=1):
  - reg_write=0, addr3=0, wdata=0.
  - All busy bits cleared.
  - Round-robin pointer last_grant=1, so src0 wins the first conflict.
  - Outputs take these values immediately, without waiting for a clock edge.
- Arbitration (combinational, one grant per cycle):
  - Only s0_valid: grant src0.
  - Only s1_valid: grant src1.
  - Both valid, FIXED_PRIO=1: grant src0.
  - Both valid, FIXED_PRIO=0: grant the source that is not last_grant.
  - sN_ready = sN_valid & grantN. A transfer occurs when valid & ready.
  - A source holds valid, addr and data stable until it sees ready; src1 may wait indefinitely only under FIXED_PRIO=1.
  - last_grant updates on every granted transfer.
- Output stage:
  - On the clk edge ending a transfer: reg_write <= (granted addr != 0), addr3 <= granted addr, wdata <= granted data.
  - With no transfer: reg_write <= 0, and addr3/wdata hold their previous values.
  - Latency: transfer at edge N, register file written at edge N+1.
  - A write to r0 is accepted (ready=1) but produces reg_write=0.
- Scoreboard (NREG bits; bit 0 is constant 0):
  - Set: at an edge with iss_valid=1 and iss_addr!=0, busy[iss_addr] <= 1.
  - Clear: at an edge with reg_write=1, busy[addr3] <= 0. This is the same edge the register file commits the data.
  - Set and clear of the same register at the same edge: set wins, because the newer producer is outstanding.
  - Set and clear of different registers at the same edge: both apply.
  - busy1 = busy[rd_addr1], busy2 = busy[rd_addr2]. Either output is 0 when its address is 0.
  - Multiple issues to the same register before writeback: a single bit is kept, and the first writeback clears it. Decode must not issue a second writer while busy is set; this block does not check for it.
- Reset mid-operation: any pending output write is dropped (reg_write forced to 0), the scoreboard is cleared, and source handshakes restart from idle.
- No counters saturate or wrap except last_grant, which is a single bit.

Test Plan:
- Reset: assert rst asynchronously between edges -> reg_write, addr3 and wdata go to 0 with no clock edge, and busy1=busy2=0 for every address.
- Single write: s0 addr=5 data=0xDEADBEEF for one cycle -> s0_ready=1 that cycle; next cycle reg_write=1, addr3=5, wdata=0xDEADBEEF; following cycle reg_write=0.
- Conflict, round-robin: s0 (addr 3, data 0x11) and s1 (addr 4, data 0x22) held valid for 3 cycles -> grants in order src0, src1, src0; addr3 sequence is 3, 4, 3, one cycle behind the grants. Repeat with FIXED_PRIO=1 -> src0 granted every cycle and s1_ready=0 throughout.
- r0 write: s1 addr=0 data=0xFFFFFFFF -> s1_ready=1, reg_write stays 0; busy1=0 with rd_addr1=0.
- Scoreboard: issue addr=7, then rd_addr1=7 -> busy1=1; s0 writes addr 7 -> busy1 stays 1 through the transfer edge and drops to 0 after the edge where reg_write=1.
- Scoreboard collision: issue addr=9 at the same edge the output stage commits addr 9 -> busy[9] remains 1. With issue addr=10 and commit addr 9 at the same edge -> busy[10]=1 and busy[9]=0.
